led7_scan_controller: RTL and testbench

//   Time-multiplexes NUM_DIGITS hex digits onto one shared Led7Decoder (S[3:0] -> D[7:0]).

---
 rtl/led7_scan_controller.sv | 142 ++++++++++++++
 tb/tb_led7_scan_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/led7_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS hex digits onto one shared 7-segment decoder,
// with per-slot anode blanking, leading-zero suppression and a double-buffered digit load.
module led7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              S,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(REFRESH_DIV - 2);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] pend_dig, act_dig;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic                    pend_flag;

  logic                    frame_end, do_copy, suppress;
  logic [IW-1:0]           next_idx, slot_idx;
  logic [4*NUM_DIGITS-1:0] src_dig;
  logic [NUM_DIGITS-1:0]   src_dp, zero_above, an_drive;

  // A slot's S/dp are taken from the buffer as it will be after this edge's copy,
  // so the first digit of a new frame already shows the freshly copied value.
  always_comb begin
    frame_end = (state == DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
    do_copy   = pend_flag && ((state == IDLE) || (en && frame_end));
    next_idx  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    slot_idx  = (state == IDLE) ? '0 : next_idx;
    src_dig   = do_copy ? pend_dig : act_dig;
    src_dp    = do_copy ? pend_dp : act_dp;
  end

  // zero_above[i]: active nibbles NUM_DIGITS-1..i are all zero.
  always_comb begin
    zero_above = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_above[i] = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (act_dig[4*j +: 4] != 4'h0) zero_above[i] = 1'b0;
      end
    end
    suppress = lz_en && (idx != '0) && zero_above[idx];
    an_drive = suppress ? AN_OFF : ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      pend_flag  <= 1'b0;
      S          <= 4'h0;
      dp         <= 1'b0;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= en && (state != IDLE) && (idx == IDX_LAST) && (cnt == CNT_PRE);

      // A load on the copy edge lands in pending and keeps the flag for the next frame.
      if (do_copy) begin
        act_dig   <= pend_dig;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (load) begin
        pend_dig  <= digits_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end

      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        an    <= AN_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
            an    <= AN_OFF;
            S     <= src_dig[{slot_idx, 2'b00} +: 4];
            dp    <= src_dp[slot_idx];
          end
          BLANK: begin
            cnt <= cnt + CW'(1);
            if (cnt == BLANK_LAST) begin
              state <= DRIVE;
              an    <= an_drive;
            end else begin
              an <= AN_OFF;
            end
          end
          DRIVE: begin
            if (cnt == CNT_LAST) begin
              state <= BLANK;
              cnt   <= '0;
              idx   <= next_idx;
              an    <= AN_OFF;
              S     <= src_dig[{slot_idx, 2'b00} +: 4];
              dp    <= src_dp[slot_idx];
            end else begin
              cnt <= cnt + CW'(1);
              an  <= an_drive;
            end
          end
          default: begin
            state <= IDLE;
            an    <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led7_scan_controller.sv
// Directed bench for led7_scan_controller (4 digits, 8-cycle slots, 2 blank cycles):
// a table of display frames plus hand-written load-timing, enable and reset sequences.
module tb_led7_scan_controller;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  S;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int t_now = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  led7_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .S(S), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  // One displayed frame: loaded value, dp bits, lz_en, and which digits must light.
  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic        lz;
    logic [3:0]  lit;
  } row_t;

  row_t rows[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got an=%b S=%h dp=%b ft=%b, expected an=%b S=%h dp=%b ft=%b",
               name, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Advance n cycles of scanning, comparing each against the slot timeline.
  task automatic run(input int n, input logic [15:0] dig, input logic [3:0] dpv,
                     input logic [3:0] lit);
    int c, d;
    logic [3:0] ea;
    logic [9:0] e;
    for (int k = 0; k < n; k++) begin
      t_now++;
      c  = (t_now - 1) % R;
      d  = ((t_now - 1) / R) % N;
      ea = (c < B || !lit[d]) ? 4'hF : ~(4'b0001 << d);
      e  = {ea, dig[d*4 +: 4], dpv[d], (d == N-1 && c == R-1)};
      exp_q.push_back(e);
      step();
      check($sformatf("scan t=%0d", t_now), {an, S, dp, frame_tick}, exp_q.pop_front());
    end
  endtask

  initial begin
    rows[0] = '{dig: 16'h1234, dpv: 4'b0001, lz: 1'b0, lit: 4'b1111};
    rows[1] = '{dig: 16'h0045, dpv: 4'b0000, lz: 1'b1, lit: 4'b0011};
    rows[2] = '{dig: 16'h0000, dpv: 4'b0000, lz: 1'b1, lit: 4'b0001};
    rows[3] = '{dig: 16'hA0F0, dpv: 4'b1010, lz: 1'b1, lit: 4'b1111};
    rows[4] = '{dig: 16'h0100, dpv: 4'b1000, lz: 1'b1, lit: 4'b0111};
    rows[5] = '{dig: 16'h1234, dpv: 4'b0000, lz: 1'b1, lit: 4'b1111};

    rst = 1'b1; en = 1'b1; load = 1'b0; lz_en = 1'b0;
    digits_in = 16'h0; dp_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset cyc%0d", i), {an, S, dp, frame_tick}, {4'hF, 4'h0, 1'b0, 1'b0});
    end
    rst = 1'b0; en = 1'b0;

    for (int r = 0; r < 6; r++) begin
      en = 1'b0;
      step();
      check($sformatf("idle row%0d", r), {an, 6'b0}, {4'hF, 6'b0});
      digits_in = rows[r].dig; dp_in = rows[r].dpv; load = 1'b1;
      step();
      load = 1'b0; lz_en = rows[r].lz; en = 1'b1; t_now = 0;
      run(33, rows[r].dig, rows[r].dpv, rows[r].lit);
    end

    // Mid-frame load is deferred to the next frame; load on the copy edge waits a frame more.
    en = 1'b0; lz_en = 1'b0;
    step();
    digits_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1; t_now = 0;
    run(11, 16'h1234, 4'b0000, 4'hF);
    digits_in = 16'hABCD; load = 1'b1;
    run(1, 16'h1234, 4'b0000, 4'hF);
    load = 1'b0;
    run(20, 16'h1234, 4'b0000, 4'hF);
    digits_in = 16'h5678; dp_in = 4'b1111; load = 1'b1;
    run(1, 16'hABCD, 4'b0000, 4'hF);
    load = 1'b0;
    run(31, 16'hABCD, 4'b0000, 4'hF);
    run(20, 16'h5678, 4'b1111, 4'hF);

    // Drop enable in digit 2 DRIVE: dark next cycle, S/dp hold, restart from digit 0.
    en = 1'b0;
    step();
    check("en_off", {an, S, dp, frame_tick}, {4'hF, 4'h6, 1'b1, 1'b0});
    step();
    check("idle_hold", {an, S, dp, frame_tick}, {4'hF, 4'h6, 1'b1, 1'b0});
    en = 1'b1; t_now = 0;
    run(13, 16'h5678, 4'b1111, 4'hF);

    // Reset in digit 1 DRIVE clears everything, including the active buffer.
    rst = 1'b1;
    step();
    check("rst_mid", {an, S, dp, frame_tick}, {4'hF, 4'h0, 1'b0, 1'b0});
    rst = 1'b0; lz_en = 1'b1; t_now = 0;
    run(33, 16'h0000, 4'b0000, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
